// File: rtl/ciq_pkg.sv
// Shared definitions for the compressed issue queue allocation logic.
// Holds queue geometry, the entry address type, the allocator FSM states
// and small popcount helpers used by the allocation controller.
package ciq_pkg;

  localparam int CIQ_DEPTH  = 16;
  localparam int DECODE_NUM = 4;
  localparam int ISSUE_NUM  = 2;
  localparam int CIQ_AW     = 4;

  typedef logic [CIQ_AW-1:0] ciq_addr_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } alloc_state_t;

  // Number of free entries in a 16-bit bitmap (0..16).
  function automatic logic [4:0] popcount16(input logic [CIQ_DEPTH-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < CIQ_DEPTH; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  // Number of requesting dispatch lanes (0..4).
  function automatic logic [2:0] popcount4(input logic [DECODE_NUM-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < DECODE_NUM; i++) c = c + {2'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ciq_free_select.sv
// Ordered free-entry picker: pick i is the (i+1)-th set bit of free_vec from bit 0.
// Purely combinational, zero latency.
// No flow control; pick_valid[i] is low when fewer than i+1 entries are free.
module ciq_free_select
  import ciq_pkg::*;
(
  input  logic [CIQ_DEPTH-1:0]  free_vec,
  output ciq_addr_t [DECODE_NUM-1:0] pick_addr,
  output logic [DECODE_NUM-1:0] pick_valid
);

  // Scan upward, handing each free index to the next unfilled pick slot.
  always_comb begin
    logic [2:0] cnt;
    cnt        = '0;
    pick_addr  = '0;
    pick_valid = '0;
    for (int b = 0; b < CIQ_DEPTH; b++) begin
      if (free_vec[b] && !cnt[2]) begin
        pick_addr[cnt[1:0]]  = ciq_addr_t'(b);
        pick_valid[cnt[1:0]] = 1'b1;
        cnt                  = cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ciq_alloc_ctrl.sv
// CIQ allocation controller: free bitmap owner, grants up to 4 entries per cycle, lowest index first.
// Grant is same-cycle (combinational ready/addresses); bitmap and count update on the next edge.
// All-or-nothing: disp_ready drops unless every requested lane fits. Optional checker: CIQ_ALLOC_CHECK_EN.
module ciq_alloc_ctrl
  import ciq_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DECODE_NUM-1:0]               disp_valid,
  output logic                                disp_ready,
  output logic [DECODE_NUM-1:0][CIQ_AW-1:0]   alloc_addr,
  input  logic [ISSUE_NUM-1:0]                rel_valid,
  input  logic [ISSUE_NUM-1:0][CIQ_AW-1:0]    rel_addr,
  input  logic                                flush,
  output logic [CIQ_DEPTH-1:0]                free_vec,
  output logic [4:0]                          free_cnt,
  output logic                                almost_full,
  output logic                                alloc_err
);

  alloc_state_t          state;
  logic [DECODE_NUM-1:0] pick_valid;
  logic [2:0]            req_cnt;
  logic [CIQ_DEPTH-1:0]  alloc_mask;
  logic [CIQ_DEPTH-1:0]  rel_mask;
  logic [CIQ_DEPTH-1:0]  free_vec_n;
  logic [4:0]            free_cnt_n;

  ciq_free_select u_sel (
    .free_vec   (free_vec),
    .pick_addr  (alloc_addr),
    .pick_valid (pick_valid)
  );

  assign req_cnt    = popcount4(disp_valid);
  assign disp_ready = (state == RUN) && !flush && ({2'b00, req_cnt} <= free_cnt);

  // Entries consumed by this cycle's grant; empty whenever the grant is refused.
  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      if (disp_valid[i] && disp_ready && pick_valid[i]) alloc_mask[alloc_addr[i]] = 1'b1;
    end
  end

  // Entries returned by issue; duplicate addresses simply OR together.
  always_comb begin
    rel_mask = '0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (rel_valid[j]) rel_mask[rel_addr[j]] = 1'b1;
    end
  end

  // Flush wins over releases; the count is recomputed from the bitmap so it cannot drift.
  assign free_vec_n = flush ? {CIQ_DEPTH{1'b1}} : ((free_vec & ~alloc_mask) | rel_mask);
  assign free_cnt_n = popcount16(free_vec_n);

  // FSM plus registered bitmap, count and almost-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      free_vec    <= {CIQ_DEPTH{1'b1}};
      free_cnt    <= 5'd16;
      almost_full <= 1'b0;
    end else begin
      case (state)
        RUN:     if (flush) state <= FLUSH;
        FLUSH:   if (!flush) state <= RUN;
        default: state <= RUN;
      endcase
      free_vec    <= free_vec_n;
      free_cnt    <= free_cnt_n;
      almost_full <= (free_cnt_n < 5'(DECODE_NUM));
    end
  end

`ifdef CIQ_ALLOC_CHECK_EN
  logic err_rel;
  logic err_noncontig;
  logic err_cnt;

  // A release during flush is discarded, so it is not treated as a double free.
  assign err_rel       = !flush && |(rel_mask & free_vec & ~alloc_mask);
  // Contiguous-from-lane-0 patterns are exactly 2^k-1.
  assign err_noncontig = |(disp_valid & (disp_valid + 4'd1));
  assign err_cnt       = (free_cnt > 5'd16);

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    alloc_err <= 1'b0;
    else if (err_rel || err_noncontig || err_cnt) alloc_err <= 1'b1;
  end
`else
  assign alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_ciq_alloc_ctrl.sv
// Directed self-checking bench for ciq_alloc_ctrl.
// Inputs change 1 time unit after a rising edge; checks happen 2 units after it.
module tb_ciq_alloc_ctrl;

  logic             clk;
  logic             rst;
  logic [3:0]       disp_valid;
  logic             disp_ready;
  logic [3:0][3:0]  alloc_addr;
  logic [1:0]       rel_valid;
  logic [1:0][3:0]  rel_addr;
  logic             flush;
  logic [15:0]      free_vec;
  logic [4:0]       free_cnt;
  logic             almost_full;
  logic             alloc_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_err;

  ciq_alloc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .alloc_addr  (alloc_addr),
    .rel_valid   (rel_valid),
    .rel_addr    (rel_addr),
    .flush       (flush),
    .free_vec    (free_vec),
    .free_cnt    (free_cnt),
    .almost_full (almost_full),
    .alloc_err   (alloc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_addrs(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                           input logic [3:0] a2, input logic [3:0] a3, input int n);
    if (n > 0) chk({tag, "_a0"}, 32'(alloc_addr[0]), 32'(a0));
    if (n > 1) chk({tag, "_a1"}, 32'(alloc_addr[1]), 32'(a1));
    if (n > 2) chk({tag, "_a2"}, 32'(alloc_addr[2]), 32'(a2));
    if (n > 3) chk({tag, "_a3"}, 32'(alloc_addr[3]), 32'(a3));
  endtask

  initial begin
`ifdef CIQ_ALLOC_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1; disp_valid = '0; rel_valid = '0; rel_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_free_vec", 32'(free_vec), 32'hFFFF);
    chk("rst_free_cnt", 32'(free_cnt), 32'd16);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_err", 32'(alloc_err), 32'd0);
    rst = 1'b0;
    tick();

    // Plan 1: empty queue, grant of four.
    disp_valid = 4'b1111; settle();
    chk("t1_ready", 32'(disp_ready), 32'd1);
    chk_addrs("t1", 4'd0, 4'd1, 4'd2, 4'd3, 4);
    tick();
    chk("t1_free_vec", 32'(free_vec), 32'hFFF0);
    chk("t1_free_cnt", 32'(free_cnt), 32'd12);
    chk("t1_af", 32'(almost_full), 32'd0);

    // Fill the rest of the queue.
    tick(); tick(); tick();
    disp_valid = 4'b0000; settle();
    chk("full_free_vec", 32'(free_vec), 32'h0000);
    chk("full_cnt", 32'(free_cnt), 32'd0);
    chk("full_af", 32'(almost_full), 32'd1);
    chk("full_ready_req0", 32'(disp_ready), 32'd1);
    disp_valid = 4'b0001; settle();
    chk("full_ready_req1", 32'(disp_ready), 32'd0);
    disp_valid = 4'b0000;

    // Build free_vec = 16'h8421 via releases.
    rel_valid = 2'b11; rel_addr[0] = 4'd0; rel_addr[1] = 4'd5; tick();
    rel_addr[0] = 4'd10; rel_addr[1] = 4'd15; tick();
    rel_valid = 2'b00; settle();
    chk("t2_free_vec", 32'(free_vec), 32'h8421);
    chk("t2_free_cnt", 32'(free_cnt), 32'd4);
    chk("t2_af", 32'(almost_full), 32'd0);

    // Plan 2: scattered picks.
    disp_valid = 4'b0111; settle();
    chk("t2_ready3", 32'(disp_ready), 32'd1);
    chk_addrs("t2_3", 4'd0, 4'd5, 4'd10, 4'd0, 3);
    disp_valid = 4'b1111; settle();
    chk("t2_ready4", 32'(disp_ready), 32'd1);
    chk_addrs("t2_4", 4'd0, 4'd5, 4'd10, 4'd15, 4);
    tick();
    disp_valid = 4'b0000; settle();
    chk("t2_next_vec", 32'(free_vec), 32'h0000);
    chk("t2_next_cnt", 32'(free_cnt), 32'd0);
    chk("t2_next_af", 32'(almost_full), 32'd1);

    // Plan 4: a released entry is not allocatable in its release cycle.
    rel_valid = 2'b01; rel_addr[0] = 4'd3; disp_valid = 4'b0001; settle();
    chk("t4_ready_same", 32'(disp_ready), 32'd0);
    tick();
    rel_valid = 2'b00; settle();
    chk("t4_free_vec", 32'(free_vec), 32'h0008);
    chk("t4_ready_next", 32'(disp_ready), 32'd1);
    chk("t4_addr0", 32'(alloc_addr[0]), 32'd3);
    tick();
    disp_valid = 4'b0000; settle();
    chk("t4_after_vec", 32'(free_vec), 32'h0000);

    // Duplicate release in one cycle frees the entry once.
    rel_valid = 2'b11; rel_addr[0] = 4'd1; rel_addr[1] = 4'd1; tick();
    rel_valid = 2'b00; settle();
    chk("dup_vec", 32'(free_vec), 32'h0002);
    chk("dup_cnt", 32'(free_cnt), 32'd1);
    rel_valid = 2'b01; rel_addr[0] = 4'd2; tick();
    rel_valid = 2'b00; settle();
    chk("t3_cnt2", 32'(free_cnt), 32'd2);

    // Plan 3: insufficient entries, refuse whole request; release makes it fit next cycle.
    disp_valid = 4'b0111; rel_valid = 2'b01; rel_addr[0] = 4'd7; settle();
    chk("t3_ready_no", 32'(disp_ready), 32'd0);
    tick();
    rel_valid = 2'b00; settle();
    chk("t3_free_vec", 32'(free_vec), 32'h0086);
    chk("t3_free_cnt", 32'(free_cnt), 32'd3);
    chk("t3_ready_yes", 32'(disp_ready), 32'd1);
    chk_addrs("t3", 4'd1, 4'd2, 4'd7, 4'd0, 3);
    tick();
    disp_valid = 4'b0000; settle();
    chk("t3_after_vec", 32'(free_vec), 32'h0000);

    // Plan 5: flush with dispatch and releases pending.
    flush = 1'b1; disp_valid = 4'b1111; rel_valid = 2'b11; rel_addr[0] = 4'd4; rel_addr[1] = 4'd8;
    settle();
    chk("t5_ready_c1", 32'(disp_ready), 32'd0);
    tick();
    flush = 1'b0; rel_valid = 2'b00; settle();
    chk("t5_ready_c2", 32'(disp_ready), 32'd0);
    chk("t5_free_vec", 32'(free_vec), 32'hFFFF);
    chk("t5_free_cnt", 32'(free_cnt), 32'd16);
    tick();
    chk("t5_ready_c3", 32'(disp_ready), 32'd1);
    chk_addrs("t5", 4'd0, 4'd1, 4'd2, 4'd3, 4);
    tick();
    disp_valid = 4'b0000; settle();
    chk("t5_after_vec", 32'(free_vec), 32'hFFF0);
    chk("t5_err_clean", 32'(alloc_err), 32'd0);

    // Legal release of an allocated entry raises no error.
    rel_valid = 2'b01; rel_addr[0] = 4'd2; tick();
    rel_valid = 2'b00; settle();
    chk("t6_legal_vec", 32'(free_vec), 32'hFFF4);
    chk("t6_legal_err", 32'(alloc_err), 32'd0);

    // Plan 6: release an entry that is already free.
    rel_valid = 2'b01; rel_addr[0] = 4'd9; tick();
    rel_valid = 2'b00; settle();
    chk("t6_err_set", 32'(alloc_err), 32'(exp_err));
    chk("t6_vec", 32'(free_vec), 32'hFFF4);
    tick(); tick(); tick();
    chk("t6_err_sticky", 32'(alloc_err), 32'(exp_err));

    // Asynchronous reset mid-operation with a grant in flight.
    disp_valid = 4'b1111; settle();
    rst = 1'b1; #1;
    chk("arst_vec", 32'(free_vec), 32'hFFFF);
    chk("arst_cnt", 32'(free_cnt), 32'd16);
    chk("arst_err", 32'(alloc_err), 32'd0);
    disp_valid = 4'b0000;
    tick();
    rst = 1'b0;
    tick();

    // Non-contiguous lanes flag a protocol error when checking is built in.
    disp_valid = 4'b0101; tick();
    disp_valid = 4'b0000; settle();
    chk("noncontig_err", 32'(alloc_err), 32'(exp_err));
    chk("noncontig_vec", 32'(free_vec), 32'hFFFA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
